controle_temporizador_jogada: RTL and testbench

Controller FSM that sequences an external `contador_163_5k`-style counter (active-low synchronous clear and load, `ent`/`enp` enables, `rco` asserted when Q==10 with `ent` high) to build the player-response timeout of the memory game. It preloads the counter, counts a configurable number of rco periods, reloads between periods, and ends each round with a one-cycle `pronto` pulse (move in time) or `timeout` pulse (too late). It sits between the game's main control unit and the timer counter in the datapath.

---
 rtl/controle_temporizador_jogada_if.sv | 20 ++
 rtl/controle_temporizador_jogada.sv | 115 +++++++++++
 tb/tb_controle_temporizador_jogada.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/controle_temporizador_jogada_if.sv
// Bus between the move-timeout controller and its contador_163-style counter.
// The controller uses the master side; the counter uses the slave side.
interface controle_temporizador_jogada_if;
  logic       cnt_clr_n;
  logic       cnt_ld_n;
  logic       cnt_ent;
  logic       cnt_enp;
  logic [3:0] cnt_d;
  logic       rco_cnt;

  modport master (
    output cnt_clr_n, cnt_ld_n, cnt_ent, cnt_enp, cnt_d,
    input  rco_cnt
  );

  modport slave (
    input  cnt_clr_n, cnt_ld_n, cnt_ent, cnt_enp, cnt_d,
    output rco_cnt
  );
endinterface

// File: rtl/controle_temporizador_jogada.sv
// Player-response timeout controller: preloads and reloads an external counter over PERIODS rco periods.
// Optional pause support is compiled in with the TEMPORIZADOR_PAUSA_EN macro.
module controle_temporizador_jogada #(
  parameter int START_VAL = 8,
  parameter int PERIODS   = 3,
  parameter int CW        = 3
) (
  input  logic          clock,
  input  logic          clr,
  input  logic          iniciar,
  input  logic          jogada,
  input  logic          cancelar,
`ifdef TEMPORIZADOR_PAUSA_EN
  input  logic          pausa,
`endif
  controle_temporizador_jogada_if.master cnt,
  output logic          ativo,
  output logic          pronto,
  output logic          timeout,
  output logic [CW-1:0] periodos
);

`ifdef TEMPORIZADOR_PAUSA_EN
  typedef enum logic [2:0] {OCIOSO, CARREGA, CONTA, RECARGA, FIM_OK, FIM_TO, PAUSA} state_t;
`else
  typedef enum logic [2:0] {OCIOSO, CARREGA, CONTA, RECARGA, FIM_OK, FIM_TO} state_t;
`endif

  localparam logic [CW-1:0] LAST = CW'(PERIODS - 1);
  localparam logic [CW-1:0] FULL = CW'(PERIODS);

  state_t        state, state_nxt;
  logic [CW-1:0] per_nxt;
  logic          clr_n, ld_n, en;

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state    <= OCIOSO;
      periodos <= '0;
    end else begin
      state    <= state_nxt;
      periodos <= per_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    per_nxt   = periodos;
    clr_n     = 1'b0;
    ld_n      = 1'b1;
    en        = 1'b0;
    ativo     = 1'b0;
    pronto    = 1'b0;
    timeout   = 1'b0;
    case (state)
      OCIOSO: begin
        if (iniciar) state_nxt = CARREGA;
      end
      CARREGA, RECARGA: begin
        clr_n = 1'b1;
        ld_n  = 1'b0;
        ativo = 1'b1;
        if (state == CARREGA) per_nxt = '0;
        if (cancelar)    state_nxt = OCIOSO;
        else if (jogada) state_nxt = FIM_OK;
        else             state_nxt = CONTA;
      end
      CONTA: begin
        clr_n = 1'b1;
        en    = 1'b1;
        ativo = 1'b1;
        // a move on the same edge as the final rco still counts as in time
        if (cancelar)    state_nxt = OCIOSO;
        else if (jogada) state_nxt = FIM_OK;
        else if (cnt.rco_cnt) begin
          if (periodos == LAST) begin
            per_nxt   = FULL;
            state_nxt = FIM_TO;
          end else begin
            per_nxt   = periodos + 1'b1;
            state_nxt = RECARGA;
          end
        end
`ifdef TEMPORIZADOR_PAUSA_EN
        else if (pausa) state_nxt = PAUSA;
`endif
      end
`ifdef TEMPORIZADOR_PAUSA_EN
      PAUSA: begin
        clr_n = 1'b1;
        ativo = 1'b1;
        if (cancelar)    state_nxt = OCIOSO;
        else if (jogada) state_nxt = FIM_OK;
        else if (!pausa) state_nxt = CONTA;
      end
`endif
      FIM_OK: begin
        pronto    = 1'b1;
        state_nxt = OCIOSO;
      end
      FIM_TO: begin
        timeout   = 1'b1;
        state_nxt = OCIOSO;
      end
      default: state_nxt = OCIOSO;
    endcase
  end

  assign cnt.cnt_clr_n = clr_n;
  assign cnt.cnt_ld_n  = ld_n;
  assign cnt.cnt_ent   = en;
  assign cnt.cnt_enp   = en;
  assign cnt.cnt_d     = 4'(START_VAL);

endmodule

// File: tb/tb_controle_temporizador_jogada.sv
// Scoreboard bench: driver pushes expected pronto/timeout pulses, a monitor pops them on each pulse.
// Includes a behavioural contador_163-style counter to close the loop on rco.
module tb_controle_temporizador_jogada;
  localparam int S  = 8;
  localparam int P  = 3;
  localparam int CW = 3;
  localparam int L  = 12 - S;
  localparam int T  = P * L;

  logic clock = 0, clr = 0, iniciar = 0, jogada = 0, cancelar = 0;
`ifdef TEMPORIZADOR_PAUSA_EN
  logic pausa = 0;
`endif
  logic ativo, pronto, timeout;
  logic [CW-1:0] periodos;
  logic [3:0] q = '0;
  int cyc = 0;
  int checks = 0, passed = 0;

  typedef struct { int kind; int per; int stamp; } exp_t;
  exp_t sbq[$];

  controle_temporizador_jogada_if bus();

  controle_temporizador_jogada #(.START_VAL(S), .PERIODS(P), .CW(CW)) dut (
    .clock(clock), .clr(clr), .iniciar(iniciar), .jogada(jogada), .cancelar(cancelar),
`ifdef TEMPORIZADOR_PAUSA_EN
    .pausa(pausa),
`endif
    .cnt(bus), .ativo(ativo), .pronto(pronto), .timeout(timeout), .periodos(periodos)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // external counter: sync clear, sync load, count with both enables
  always @(posedge clock) begin
    if (!bus.cnt_clr_n)                q <= '0;
    else if (!bus.cnt_ld_n)            q <= bus.cnt_d;
    else if (bus.cnt_ent && bus.cnt_enp) q <= q + 4'd1;
  end
  assign bus.rco_cnt = (q == 4'd10) && bus.cnt_ent;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // monitor: every pronto/timeout must match the head of the scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (pronto || timeout) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: pronto=%0d timeout=%0d at cycle %0d, expected none",
                 pronto, timeout, cyc);
      end else begin
        e = sbq.pop_front();
        chk("pulse_kind", int'({pronto, timeout}), e.kind);
        chk("pulse_periodos", int'(periodos), e.per);
        chk("pulse_cycle", cyc, e.stamp);
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_clr_n"}, int'(bus.cnt_clr_n), 0);
    chk({tag, "_ld_n"}, int'(bus.cnt_ld_n), 1);
    chk({tag, "_ent"}, int'(bus.cnt_ent), 0);
    chk({tag, "_enp"}, int'(bus.cnt_enp), 0);
    chk({tag, "_ativo"}, int'(ativo), 0);
    chk({tag, "_pronto"}, int'(pronto), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_periodos"}, int'(periodos), 0);
  endtask

  // One round. kj/kc/kp: edge index (from E0) where jogada/cancelar/iniciar is sampled, 0 = none.
  // Pause window: pausa sampled at edges pz_start..pz_start+pz_len-1.
  task automatic run_round(int kj, int kc, int kp, int pz_start, int pz_len, bit wave, int prevp);
    int e0, tend, last;
    exp_t e;
    tend = T + pz_len;
    iniciar = 1;
    e0 = cyc + 1;
    if (kc > 0 && kc <= tend && (kj == 0 || kc <= kj)) begin
      // cancelled: nothing expected
    end else if (kj > 0 && kj <= tend) begin
      e.kind = 2; e.per = (kj - 1) / L; e.stamp = e0 + kj;
      sbq.push_back(e);
    end else begin
      e.kind = 1; e.per = P; e.stamp = e0 + tend;
      sbq.push_back(e);
    end
    last = tend;
    if (kj > last) last = kj;
    if (kc > last) last = kc;
    last = last + 1;
    @(negedge clock);
    for (int k = 0; k <= last; k++) begin
      // here the DUT has just taken edge Ek
      if (wave && k <= T) begin
        chk("wave_ld_n", int'(bus.cnt_ld_n), (k == 0 || (k % L == 0 && k < T)) ? 0 : 1);
        chk("wave_ativo", int'(ativo), (k < T) ? 1 : 0);
        if (k < T) chk("wave_ent", int'(bus.cnt_ent), (k == 0 || k % L == 0) ? 0 : 1);
      end
      if (prevp >= 0 && k == 0) chk("periodos_held_E0", int'(periodos), prevp);
      if (prevp >= 0 && k == 1) chk("periodos_clear_E1", int'(periodos), 0);
      if (pz_len > 0 && k >= pz_start && k < pz_start + pz_len) begin
        chk("pause_ent", int'(bus.cnt_ent), 0);
        chk("pause_enp", int'(bus.cnt_enp), 0);
      end
      iniciar  = (kp > 0 && k + 1 == kp);
      jogada   = (k + 1 == kj);
      cancelar = (k + 1 == kc);
`ifdef TEMPORIZADOR_PAUSA_EN
      pausa = (pz_len > 0 && k + 1 >= pz_start && k + 1 < pz_start + pz_len);
`endif
      @(negedge clock);
    end
    iniciar = 0; jogada = 0; cancelar = 0;
    chk("scoreboard_drained", sbq.size(), 0);
    chk("idle_ativo", int'(ativo), 0);
  endtask

  initial begin
    int mode, kj, kc, gap;
    // reset
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    chk("reset_cnt_d", int'(bus.cnt_d), S);
    clr = 1;
    repeat (2) @(negedge clock);
    chk("idle_clr_n", int'(bus.cnt_clr_n), 0);
    chk("idle_ativo0", int'(ativo), 0);

    // full timeout round with waveform checks; stray iniciar mid-round is ignored
    run_round(0, 0, 2, 0, 0, 1'b1, -1);
    @(negedge clock);
    // move sampled at E6
    run_round(6, 0, 0, 0, 0, 1'b0, -1);
    chk("periodos_hold_idle", int'(periodos), 1);
    @(negedge clock);
    // move together with the final rco; periodos must restart from 0 after E1
    run_round(T, 0, 0, 0, 0, 1'b0, 1);
    @(negedge clock);
    // cancel and move together
    run_round(3, 3, 0, 0, 0, 1'b0, -1);
    @(negedge clock);

    // asynchronous reset mid-round
    iniciar = 1;
    @(negedge clock);
    iniciar = 0;
    repeat (6) @(negedge clock);
    #2 clr = 0;
    #1 check_reset_outputs("midreset");
    @(negedge clock);
    clr = 1;
    repeat (2) @(negedge clock);
    chk("midreset_drained", sbq.size(), 0);

`ifdef TEMPORIZADOR_PAUSA_EN
    run_round(0, 0, 0, 2, 5, 1'b0, -1);
    @(negedge clock);
`endif

    // randomized rounds with stray controls in the idle gaps
    for (int r = 0; r < 24; r++) begin
      mode = $urandom_range(0, 3);
      kj = 0; kc = 0;
      case (mode)
        1: kj = $urandom_range(1, T + 2);
        2: begin
          kc = $urandom_range(1, T);
          kj = ($urandom_range(0, 1) == 1) ? kc + $urandom_range(0, 2) : 0;
        end
        3: kj = L * $urandom_range(1, P);
        default: ;
      endcase
      run_round(kj, kc, 0, 0, 0, 1'b0, -1);
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        jogada   = ($urandom_range(0, 1) == 1);
        cancelar = ($urandom_range(0, 1) == 1);
        @(negedge clock);
      end
      jogada = 0; cancelar = 0;
      @(negedge clock);
    end

    repeat (3) @(negedge clock);
    chk("final_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
